fifo_sync_ctrl: RTL and testbench

- Parametrised synchronous FIFO that succeeds the fixed 32x8 FIFO RAM: a storage array plus FSM-controlled write/read pointers.
- Provides occupancy tracking, full/empty and programmable almost flags, overflow/underflow detection and a synchronous flush.
- Sits between a producer and a consumer on the same clock domain. Callers no longer drive addresses.

---
 rtl/fifo_sync_ctrl_if.sv | 45 ++++
 rtl/fifo_sync_ctrl.sv | 127 ++++++++++++
 tb/tb_fifo_sync_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_ctrl_if.sv
// rtl/fifo_sync_ctrl_if.sv - producer/consumer bundle for the synchronous FIFO controller
//
// Purpose : groups the FIFO access, status and error signals into one bundle.
// Modports:
//   master : the producer/consumer side; drives flush, wr_en, data_in and rd_en.
//   slave  : the FIFO side; drives data_out, rd_valid, flags, count and errors.
// Signals :
//   flush        sync active-high flush
//   wr_en        write request, data_in the write word
//   rd_en        read request, data_out the registered read word
//   rd_valid     data_out carries the word read on the previous cycle
//   full/empty   occupancy at DEPTH / 0
//   almost_full  count >= AF_LEVEL; almost_empty count <= AE_LEVEL
//   count        occupancy 0..DEPTH
//   overflow     rejected write; underflow rejected read
interface fifo_sync_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - parametrised synchronous FIFO with FSM-controlled pointers
//
// Purpose : single-clock FIFO with occupancy count, full/empty and programmable
//           almost flags, overflow/underflow detection and a synchronous flush.
// Ports   :
//   clk    rising-edge clock
//   Clear  asynchronous active-low reset (memory contents are not cleared)
//   bus    fifo_sync_ctrl_if.slave; see the interface file for signal list
// Config  : define FIFO_STICKY_ERR_EN to make overflow/underflow sticky until
//           Clear or flush; otherwise they are one-cycle registered pulses.
module fifo_sync_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic           clk,
  input  logic           Clear,
  fifo_sync_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] AF_L  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L  = (ADDR_W+1)'(AE_LEVEL);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_NORMAL = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [(1<<ADDR_W)];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, count_nxt;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic              overflow_q, underflow_q;

  logic full_w, empty_w;
  logic rd_acc, wr_acc;
  logic ovf_evt, udf_evt;

  // Flags come only from registered state/count, never from the requests.
  assign empty_w = (state_q == ST_EMPTY);
  assign full_w  = (state_q == ST_FULL);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc  = bus.rd_en && !empty_w && !bus.flush;
  assign wr_acc  = bus.wr_en && (!full_w || rd_acc) && !bus.flush;
  assign ovf_evt = bus.wr_en && !wr_acc && !bus.flush;
  assign udf_evt = bus.rd_en && !rd_acc && !bus.flush;

  assign count_nxt = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY:  if (wr_acc) state_d = (count_nxt == DEPTH) ? ST_FULL : ST_NORMAL;
        ST_NORMAL: begin
          if (count_nxt == '0)        state_d = ST_EMPTY;
          else if (count_nxt == DEPTH) state_d = ST_FULL;
        end
        ST_FULL:   if (rd_acc && !wr_acc) state_d = (count_nxt == '0) ? ST_EMPTY : ST_NORMAL;
        default:   state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Storage has no reset; writes are blocked while Clear is held low.
  always_ff @(posedge clk) begin
    if (wr_acc && Clear) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr     <= rd_ptr + 1'b1;
        data_out_q <= mem[rd_ptr];
      end
      rd_valid_q <= rd_acc;
      count_q    <= count_nxt;
`ifdef FIFO_STICKY_ERR_EN
      overflow_q  <= overflow_q  | ovf_evt;
      underflow_q <= underflow_q | udf_evt;
`else
      overflow_q  <= ovf_evt;
      underflow_q <= udf_evt;
`endif
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_L);
  assign bus.almost_empty = (count_q <= AE_L);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - self-checking bench for fifo_sync_ctrl against a queue model
module tb_fifo_sync_ctrl;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int AF = 28;
  localparam int AE = 4;

  logic clk = 1'b0;
  logic Clear = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fifo_sync_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk   (clk),
    .Clear (Clear),
    .bus   (bus.slave)
  );

  int tests_run = 0;
  int fails = 0;

  // Reference model: a queue plus the registered outputs it implies.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_rv, m_ovf, m_udf;

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_rv = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Drive one cycle of requests, advance the model, sample #1 after the edge.
  task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd, input logic fl);
    bit r_ok, w_ok, oe, ue;
    bus.wr_en = wr;
    bus.data_in = din;
    bus.rd_en = rd;
    bus.flush = fl;
    r_ok = rd && (q.size() > 0);
    w_ok = wr && ((q.size() < DEPTH) || r_ok);
    if (fl) begin
      q.delete();
      m_rv = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      oe = wr && !w_ok;
      ue = rd && !r_ok;
      if (r_ok) m_dout = q.pop_front();
      if (w_ok) q.push_back(din);
      m_rv = r_ok;
`ifdef FIFO_STICKY_ERR_EN
      m_ovf = m_ovf | oe;
      m_udf = m_udf | ue;
`else
      m_ovf = oe;
      m_udf = ue;
`endif
    end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    Clear = 1'b0;
    model_reset();
    #7;
    Clear = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.rd_en = 0; bus.flush = 0; bus.data_in = '0;
    Clear = 1'b0;
    model_reset();
    #12;
    tests_run++;
    if ({bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
         bus.rd_valid, bus.overflow, bus.underflow, bus.data_out} !== {6'd0, 7'b1010000, 8'h00}) begin
      fails++;
      $display("FAIL reset_state: count=%0d e=%b f=%b ae=%b af=%b rv=%b ov=%b un=%b dout=%h, required 0 1 0 1 0 0 0 0 00",
               bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
               bus.rd_valid, bus.overflow, bus.underflow, bus.data_out);
    end
    Clear = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      tests_run++;
      if ({bus.count, bus.almost_empty, bus.almost_full, bus.full, bus.empty} !==
          {6'(i+1), (i+1 <= AE), (i+1 >= AF), (i+1 == DEPTH), 1'b0}) begin
        fails++;
        $display("FAIL fill_%0d: count=%0d ae=%b af=%b full=%b empty=%b, required count=%0d ae=%b af=%b full=%b empty=0",
                 i, bus.count, bus.almost_empty, bus.almost_full, bus.full, bus.empty,
                 i+1, (i+1 <= AE), (i+1 >= AF), (i+1 == DEPTH));
      end
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    tests_run++;
    if (bus.count !== 6'd32 || bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
      fails++;
      $display("FAIL overflow: count=%0d ov=%b full=%b, required 32 1 1", bus.count, bus.overflow, bus.full);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    tests_run++;
`ifdef FIFO_STICKY_ERR_EN
    if (bus.overflow !== 1'b1) begin
`else
    if (bus.overflow !== 1'b0) begin
`endif
      fails++;
      $display("FAIL overflow_after: ov=%b, required %b", bus.overflow, m_ovf);
    end
  endtask

  task automatic test_full_simul();
    step(1'b1, 8'h55, 1'b1, 1'b0);
    tests_run++;
    if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b1 || bus.count !== 6'd32 || bus.full !== 1'b1) begin
      fails++;
      $display("FAIL full_simul: dout=%h rv=%b count=%0d full=%b, required 00 1 32 1",
               bus.data_out, bus.rd_valid, bus.count, bus.full);
    end
  endtask

  task automatic test_wrap_drain();
    logic [DW-1:0] exp, w[8];
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      exp = (i < DEPTH-1) ? DW'(i+1) : 8'h55;
      tests_run++;
      if (bus.data_out !== exp || bus.rd_valid !== 1'b1) begin
        fails++;
        $display("FAIL drain_%0d: dout=%h rv=%b, required %h 1", i, bus.data_out, bus.rd_valid, exp);
      end
    end
    tests_run++;
    if (bus.empty !== 1'b1 || bus.count !== 6'd0) begin
      fails++;
      $display("FAIL drain_empty: empty=%b count=%0d, required 1 0", bus.empty, bus.count);
    end
    for (int i = 0; i < 8; i++) begin
      w[i] = DW'($urandom);
      step(1'b1, w[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (bus.data_out !== w[i]) begin
        fails++;
        $display("FAIL wrap_rd_%0d: dout=%h, required %h", i, bus.data_out, w[i]);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    tests_run++;
    if (bus.rd_valid !== 1'b0 || bus.data_out !== w[7]) begin
      fails++;
      $display("FAIL hold: rv=%b dout=%h, required 0 %h", bus.rd_valid, bus.data_out, w[7]);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    tests_run++;
    if (bus.underflow !== 1'b1 || bus.count !== 6'd1 || bus.empty !== 1'b0 ||
        bus.full !== 1'b0 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL underflow: un=%b count=%0d empty=%b full=%b rv=%b, required 1 1 0 0 0",
               bus.underflow, bus.count, bus.empty, bus.full, bus.rd_valid);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if (bus.data_out !== 8'h3C || bus.rd_valid !== 1'b1 || bus.empty !== 1'b1) begin
      fails++;
      $display("FAIL underflow_rd: dout=%h rv=%b empty=%b, required 3c 1 1", bus.data_out, bus.rd_valid, bus.empty);
    end
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.data_in = 8'h77;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    bus.wr_en = 1'b1;
    bus.data_in = 8'h77;
    #2;
    Clear = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (bus.count !== 6'd0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0 || bus.data_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid: count=%0d empty=%b rv=%b dout=%h, required 0 1 0 00",
               bus.count, bus.empty, bus.rd_valid, bus.data_out);
    end
    bus.wr_en = 1'b0;
    @(posedge clk);
    #3;
    Clear = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.count !== 6'd0 || bus.empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: count=%0d empty=%b, required 0 1", bus.count, bus.empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    tests_run++;
    if (bus.count !== 6'd7) begin
      fails++;
      $display("FAIL flush_pre: count=%0d, required 7", bus.count);
    end
    step(1'b1, 8'hE1, 1'b0, 1'b1);
    tests_run++;
    if (bus.count !== 6'd0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush: count=%0d empty=%b rv=%b, required 0 1 0", bus.count, bus.empty, bus.rd_valid);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0 || bus.count !== 6'd0) begin
      fails++;
      $display("FAIL flush_ignored_wr: un=%b rv=%b count=%0d, required 1 0 0", bus.underflow, bus.rd_valid, bus.count);
    end
  endtask

  task automatic test_random();
    logic wr, rd, fl;
    int mcount;
    for (int c = 0; c < 600; c++) begin
      // Bias write/read rates per phase so the FIFO visits both boundaries.
      wr = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 75 : 30));
      rd = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 30 : 75));
      fl = ($urandom_range(0, 199) == 0);
      step(wr, DW'($urandom), rd, fl);
      mcount = q.size();
      tests_run++;
      if (bus.count !== 6'(mcount) || bus.empty !== (mcount == 0) || bus.full !== (mcount == DEPTH) ||
          bus.almost_empty !== (mcount <= AE) || bus.almost_full !== (mcount >= AF) ||
          bus.rd_valid !== m_rv || bus.data_out !== m_dout ||
          bus.overflow !== m_ovf || bus.underflow !== m_udf) begin
        fails++;
        $display("FAIL random_%0d: count=%0d e=%b f=%b ae=%b af=%b rv=%b dout=%h ov=%b un=%b, required %0d %b %b %b %b %b %h %b %b",
                 c, bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
                 bus.rd_valid, bus.data_out, bus.overflow, bus.underflow,
                 mcount, (mcount == 0), (mcount == DEPTH), (mcount <= AE), (mcount >= AF),
                 m_rv, m_dout, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_simul();
    test_wrap_drain();
    test_underflow();
    test_reset_midburst();
    test_flush();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
